johnson_seq_ctrl: RTL and testbench

- Sequencer/controller around a WIDTH-bit Johnson ring that gives 2*WIDTH ordered phases.
- Starts, pauses, stops and seeds the ring, counts completed laps, and ends after a programmed lap count.
- Outputs one-hot phase strobes to downstream time-multiplexed logic.
- Rejects illegal seed values and corrects them.

---
 rtl/johnson_seq_pkg.sv | 35 +++
 rtl/johnson_shift_core.sv | 22 ++
 rtl/johnson_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/johnson_seq_pkg.sv
// Shared definitions for the Johnson-ring sequencer: FSM encodings,
// phase count and the ring legality / phase-index helpers.
package johnson_seq_pkg;

    localparam int WIDTH_DFLT = 4;
    localparam int NPHASE     = 2 * WIDTH_DFLT;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    // A legal Johnson state has at most one 0/1 boundary between adjacent bits
    // (all zeros, all ones, ones packed from the MSB, or ones packed from the LSB).
    function automatic logic ring_legal(input logic [31:0] v, input int w);
        int edges;
        edges = 0;
        for (int i = 0; i < 31; i++) begin
            if ((i < w - 1) && (v[i] != v[i+1])) edges++;
        end
        return (edges <= 1);
    endfunction

    // Ones filling from the MSB count up 0..w; ones draining toward the LSB
    // continue the count w+1..2w-1.
    function automatic int ring_index(input logic [31:0] v, input int w);
        int ones;
        ones = 0;
        for (int i = 0; i < 32; i++) begin
            if ((i < w) && v[i]) ones++;
        end
        if (v[w-1] || (ones == 0)) return ones;
        return 2 * w - ones;
    endfunction

endpackage

// File: rtl/johnson_shift_core.sv
// Johnson ring register with clear / load / step controls.
module johnson_shift_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] q
);

    // Ring update, priority rst > clr > ld > en.
    always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (clr) q <= '0;
        else if (ld)  q <= ld_val;
        else if (en)  q <= {~q[0], q[WIDTH-1:1]};
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequencer around a Johnson ring: start/pause/stop/seed, lap counting,
// programmed run length and one-hot phase strobes.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | ring parked; accepts load and start
// ST_RUN   | ring steps every edge, laps counted at wrap
// ST_PAUSE | ring and lap count held until pause drops
module johnson_seq_ctrl
    import johnson_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DFLT,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [CNT_W-1:0]   num_laps,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] phase,
    output logic [CNT_W-1:0]   lap_cnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int NPH   = 2 * WIDTH;
    localparam int IDX_W = (NPH > 2) ? $clog2(NPH) : 1;

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] target, target_nxt, lap_nxt, lap_inc;
    logic             done_nxt, err_nxt;
    logic             core_en, core_clr, core_ld;
    logic [IDX_W-1:0] idx;
    logic             wrap;

    johnson_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .en     (core_en),
        .clr    (core_clr),
        .ld     (core_ld),
        .ld_val (load_val),
        .q      (q)
    );

    // Decode current ring state into its phase index and one-hot strobe.
    always_comb begin
        idx          = IDX_W'(ring_index(32'(q), WIDTH));
        phase        = '0;
        phase[idx]   = 1'b1;
    end

    assign wrap    = (idx == IDX_W'(NPH - 1));
    assign lap_inc = lap_cnt + CNT_W'(1);

    // Next-state, ring control and pulse generation.
    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        lap_nxt    = lap_cnt;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        core_en    = 1'b0;
        core_clr   = 1'b0;
        core_ld    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_RUN;
                    lap_nxt    = '0;
                    target_nxt = num_laps;
                end else if (load) begin
                    if (ring_legal(32'(load_val), WIDTH)) begin
                        core_ld = 1'b1;
                    end else begin
                        core_clr = 1'b1;
                        err_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    core_clr  = 1'b1;
                end else if (pause) begin
                    state_nxt = ST_PAUSE;
                end else begin
                    core_en = 1'b1;
                    if (wrap) begin
                        lap_nxt = lap_inc;
                        // Final wrap lands the ring on 0 by the step itself.
                        if ((target != '0) && (lap_inc == target)) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                    core_clr  = 1'b1;
                end else if (!pause) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Controller registers; busy is a registered view of RUN/PAUSE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            target  <= '0;
            lap_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            target  <= target_nxt;
            lap_cnt <= lap_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= done_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed bench for johnson_seq_ctrl with hand-computed expectations.
module tb_johnson_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, pause, load;
    logic [7:0] num_laps;
    logic [3:0] load_val;
    logic [3:0] q;
    logic [7:0] phase;
    logic [7:0] lap_cnt;
    logic       busy, done, err;

    logic       start2, stop2, pause2, load2;
    logic [1:0] num_laps2;
    logic [3:0] load_val2;
    logic [3:0] q2;
    logic [7:0] phase2;
    logic [1:0] lap_cnt2;
    logic       busy2, done2, err2;

    int tests = 0;
    int fails = 0;

    logic [3:0] seq_q  [0:7];
    logic [7:0] seq_ph [0:7];

    always #5 clk = ~clk;

    johnson_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .num_laps(num_laps), .load(load), .load_val(load_val),
        .q(q), .phase(phase), .lap_cnt(lap_cnt), .busy(busy), .done(done), .err(err)
    );

    johnson_seq_ctrl #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop2), .pause(pause2),
        .num_laps(num_laps2), .load(load2), .load_val(load_val2),
        .q(q2), .phase(phase2), .lap_cnt(lap_cnt2), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        seq_q[0] = 4'h0; seq_q[1] = 4'h8; seq_q[2] = 4'hC; seq_q[3] = 4'hE;
        seq_q[4] = 4'hF; seq_q[5] = 4'h7; seq_q[6] = 4'h3; seq_q[7] = 4'h1;
        for (int i = 0; i < 8; i++) seq_ph[i] = 8'h01 << i;

        rst = 1'b1; start = 0; stop = 0; pause = 0; load = 0;
        num_laps = 0; load_val = 0;
        start2 = 0; stop2 = 0; pause2 = 0; load2 = 0; num_laps2 = 0; load_val2 = 0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_phase", 32'(phase), 32'h01);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_lap", 32'(lap_cnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);

        // single lap
        num_laps = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_busy0", 32'(busy), 32'h1);
        chk("s1_q0", 32'(q), 32'h0);
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk($sformatf("s1_q%0d", e), 32'(q), 32'(seq_q[e % 8]));
            chk($sformatf("s1_ph%0d", e), 32'(phase), 32'(seq_ph[e % 8]));
            chk($sformatf("s1_done%0d", e), 32'(done), (e == 8) ? 32'h1 : 32'h0);
        end
        chk("s1_busy_end", 32'(busy), 32'h0);
        chk("s1_lap_end", 32'(lap_cnt), 32'h1);
        tick();
        chk("s1_done_clr", 32'(done), 32'h0);

        // pause: ring frozen on edges 4,5 (PAUSE) and 6 (back to RUN)
        num_laps = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("pz_q3", 32'(q), 32'hE);
        pause = 1'b1;
        tick();
        chk("pz_q4", 32'(q), 32'hE);
        tick();
        chk("pz_q5", 32'(q), 32'hE);
        chk("pz_ph5", 32'(phase), 32'h08);
        chk("pz_busy5", 32'(busy), 32'h1);
        pause = 1'b0;
        tick();
        chk("pz_q6", 32'(q), 32'hE);
        tick();
        chk("pz_q7", 32'(q), 32'hF);
        for (int e = 8; e <= 19; e++) begin
            tick();
            chk($sformatf("pz_done%0d", e), 32'(done), (e == 19) ? 32'h1 : 32'h0);
        end
        chk("pz_q_end", 32'(q), 32'h0);
        chk("pz_lap_end", 32'(lap_cnt), 32'h2);
        chk("pz_busy_end", 32'(busy), 32'h0);

        // stop at 0011
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        chk("st_q6", 32'(q), 32'h3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("st_q", 32'(q), 32'h0);
        chk("st_busy", 32'(busy), 32'h0);
        chk("st_lap", 32'(lap_cnt), 32'h0);
        chk("st_done", 32'(done), 32'h0);
        tick();
        chk("st_done2", 32'(done), 32'h0);

        // seeding
        load = 1'b1; load_val = 4'h7;
        tick();
        load = 1'b0;
        chk("sd_q", 32'(q), 32'h7);
        chk("sd_err", 32'(err), 32'h0);
        num_laps = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("sd_q_start", 32'(q), 32'h7);
        tick();
        chk("sd_q1", 32'(q), 32'h3);
        chk("sd_done1", 32'(done), 32'h0);
        tick();
        chk("sd_q2", 32'(q), 32'h1);
        tick();
        chk("sd_q3", 32'(q), 32'h0);
        chk("sd_done3", 32'(done), 32'h1);
        chk("sd_lap3", 32'(lap_cnt), 32'h1);
        load = 1'b1; load_val = 4'hC;
        tick();
        chk("sd_q_c", 32'(q), 32'hC);
        load_val = 4'h5;
        tick();
        load = 1'b0;
        chk("sd_bad_q", 32'(q), 32'h0);
        chk("sd_bad_err", 32'(err), 32'h1);
        tick();
        chk("sd_err_clr", 32'(err), 32'h0);

        // ignored inputs while busy (free-run target latched as 0)
        num_laps = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("ig_q2", 32'(q), 32'hC);
        start = 1'b1; load = 1'b1; load_val = 4'hF; num_laps = 8'd1;
        tick();
        start = 1'b0; load = 1'b0;
        chk("ig_q3", 32'(q), 32'hE);
        chk("ig_err", 32'(err), 32'h0);
        for (int e = 4; e <= 9; e++) tick();
        chk("ig_q9", 32'(q), 32'h8);
        chk("ig_lap9", 32'(lap_cnt), 32'h1);
        chk("ig_done9", 32'(done), 32'h0);
        chk("ig_busy9", 32'(busy), 32'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("ig_stop_busy", 32'(busy), 32'h0);

        // reset mid-run
        num_laps = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        chk("rm_q5", 32'(q), 32'h7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_q", 32'(q), 32'h0);
        chk("rm_busy", 32'(busy), 32'h0);
        chk("rm_lap", 32'(lap_cnt), 32'h0);
        chk("rm_done", 32'(done), 32'h0);

        // free-run wrap on the 2-bit lap counter
        num_laps2 = 2'd0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int s = 1; s <= 40; s++) begin
            tick();
            chk($sformatf("fr_done%0d", s), 32'(done2), 32'h0);
            if (s % 8 == 0)
                chk($sformatf("fr_lap%0d", s), 32'(lap_cnt2), 32'((s / 8) % 4));
        end
        chk("fr_busy", 32'(busy2), 32'h1);
        stop2 = 1'b1;
        tick();
        stop2 = 1'b0;
        chk("fr_stop_busy", 32'(busy2), 32'h0);
        chk("fr_stop_q", 32'(q2), 32'h0);
        chk("fr_stop_lap", 32'(lap_cnt2), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
